alu_mdu: RTL and testbench

Parametrised execute-stage arithmetic unit for the MIPS datapath: single-cycle logic/arithmetic/compare operations plus an iterative multiply/divide unit with architectural HI/LO registers. Sits in the execute stage, fed by the register file / immediate mux and the ALU decoder. Provides the start/busy/done handshake the control unit uses to stall on mult/div and mfhi/mflo hazards.

---
 rtl/alu_mdu.sv | 168 ++++++++++++++++
 tb/tb_alu_mdu.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// Execute-stage ALU with an iterative multiply/divide unit and architectural HI/LO.
// Logic ops are combinational; MULT/DIV run one bit per cycle behind a start/busy/done handshake.
module alu_mdu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] srcA,
    input  logic [DATA_WIDTH-1:0] srcB,
    input  logic [3:0]            alu_control,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] alu_result,
    output logic                  zero,
    output logic                  overflow,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    acc_hi_q;
    logic [W-1:0]    acc_lo_q;
    logic [W-1:0]    opnd_q;
    logic [W-1:0]    hi_q;
    logic [W-1:0]    lo_q;
    logic            sign_a_q;
    logic            sign_b_q;
    logic            is_div_q;

    logic [W-1:0]    sum;
    logic [W-1:0]    diff;

    always_comb begin
        sum        = srcA + srcB;
        diff       = srcA - srcB;
        alu_result = '0;
        overflow   = 1'b0;
        case (alu_control)
            4'b0000: alu_result = srcA & srcB;
            4'b0001: alu_result = srcA | srcB;
            4'b0010: begin
                alu_result = sum;
                overflow   = (srcA[W-1] == srcB[W-1]) && (sum[W-1] != srcA[W-1]);
            end
            4'b0011: alu_result = srcA ^ srcB;
            4'b0100: alu_result = ~(srcA | srcB);
            4'b0101: alu_result = W'(srcA < srcB);
            4'b0110: begin
                alu_result = diff;
                overflow   = (srcA[W-1] != srcB[W-1]) && (diff[W-1] != srcA[W-1]);
            end
            4'b0111: alu_result = W'($signed(srcA) < $signed(srcB));
            4'b1100: alu_result = hi_q;
            4'b1101: alu_result = lo_q;
            default: alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

    logic            is_seq;
    logic            is_signed;
    logic            neg_a;
    logic            neg_b;
    logic [W-1:0]    abs_a;
    logic [W-1:0]    abs_b;

    always_comb begin
        is_seq    = (alu_control[3:2] == 2'b10);
        is_signed = is_seq && !alu_control[0];
        neg_a     = is_signed && srcA[W-1];
        neg_b     = is_signed && srcB[W-1];
        abs_a     = neg_a ? -srcA : srcA;
        abs_b     = neg_b ? -srcB : srcB;
    end

    // Iteration datapath: acc_hi holds partial product / remainder,
    // acc_lo holds the multiplier being consumed / dividend becoming quotient.
    logic [W:0]      mul_sum;
    logic [W:0]      div_sh;
    logic            div_ge;
    logic [W-1:0]    div_sub;
    logic [2*W-1:0]  prod_fin;
    logic [W-1:0]    quo_fin;
    logic [W-1:0]    rem_fin;

    always_comb begin
        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
        div_sh   = {acc_hi_q, acc_lo_q[W-1]};
        div_ge   = (div_sh >= {1'b0, opnd_q});
        div_sub  = div_sh[W-1:0] - opnd_q;
        prod_fin = (sign_a_q ^ sign_b_q) ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
        quo_fin  = (sign_a_q ^ sign_b_q) ? -acc_lo_q : acc_lo_q;
        rem_fin  = sign_a_q ? -acc_hi_q : acc_hi_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            is_div_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && is_seq) begin
                        sign_a_q <= neg_a;
                        sign_b_q <= neg_b;
                        is_div_q <= alu_control[1];
                        cnt_q    <= '0;
                        acc_hi_q <= '0;
                        if (alu_control[1]) begin
                            acc_lo_q <= abs_a;
                            opnd_q   <= abs_b;
                            state_q  <= DIV;
                        end else begin
                            acc_lo_q <= abs_b;
                            opnd_q   <= abs_a;
                            state_q  <= MUL;
                        end
                    end
                end
                MUL: begin
                    acc_hi_q <= mul_sum[W:1];
                    acc_lo_q <= {mul_sum[0], acc_lo_q[W-1:1]};
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CW'(W-1)) state_q <= DONE;
                end
                DIV: begin
                    acc_hi_q <= div_ge ? div_sub : div_sh[W-1:0];
                    acc_lo_q <= {acc_lo_q[W-2:0], div_ge};
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CW'(W-1)) state_q <= DONE;
                end
                DONE: begin
                    if (is_div_q) begin
                        // With a zero divisor the remainder path ends holding |srcA|,
                        // so rem_fin already reproduces the original dividend.
                        hi_q <= rem_fin;
                        lo_q <= (opnd_q == '0) ? '1 : quo_fin;
                    end else begin
                        {hi_q, lo_q} <= prod_fin;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Randomised scoreboard bench for alu_mdu: stimulus pushes expected HI/LO,
// a monitor pops and compares on every done pulse.
module tb_alu_mdu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] srcA = '0;
    logic [W-1:0] srcB = '0;
    logic [3:0]   alu_control = '0;
    logic         start = 1'b0;
    logic [W-1:0] alu_result;
    logic         zero;
    logic         overflow;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    alu_mdu #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .srcA(srcA), .srcB(srcB),
        .alu_control(alu_control), .start(start), .alu_result(alu_result),
        .zero(zero), .overflow(overflow), .busy(busy), .done(done),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           done_cyc;
        string        name;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] arch_hi = '0;
    logic [W-1:0] arch_lo = '0;
    int           issued = 0;
    int           done_seen = 0;

    function automatic logic [2*W-1:0] ref_mdu(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
        longint          sa, sbv, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     p;
        sa = $signed(a);
        sbv = $signed(b);
        ua = a;
        ub = b;
        p = '0;
        case (op)
            4'b1000: p = sa * sbv;
            4'b1001: p = ua * ub;
            4'b1010: begin
                if (b == 0) p = {a, {W{1'b1}}};
                else begin
                    q = sa / sbv;
                    r = sa % sbv;
                    p = {r[W-1:0], q[W-1:0]};
                end
            end
            default: begin
                if (b == 0) p = {a, {W{1'b1}}};
                else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    p = {ur[W-1:0], uq[W-1:0]};
                end
            end
        endcase
        return p[2*W-1:0];
    endfunction

    function automatic logic [W:0] ref_alu(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b,
                                           logic [W-1:0] hv, logic [W-1:0] lv);
        longint       sa, sbv, s, lim_hi, lim_lo;
        logic [W-1:0] r;
        logic         ov;
        sa = $signed(a);
        sbv = $signed(b);
        lim_hi = (longint'(1) <<< (W-1)) - 1;
        lim_lo = -(longint'(1) <<< (W-1));
        r = '0;
        ov = 1'b0;
        case (op)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: begin s = sa + sbv; r = a + b; ov = (s > lim_hi) || (s < lim_lo); end
            4'h3: r = a ^ b;
            4'h4: r = ~(a | b);
            4'h5: r = (a < b) ? 1 : 0;
            4'h6: begin s = sa - sbv; r = a - b; ov = (s > lim_hi) || (s < lim_lo); end
            4'h7: r = (sa < sbv) ? 1 : 0;
            4'hC: r = hv;
            4'hD: r = lv;
            default: r = '0;
        endcase
        return {ov, r};
    endfunction

    // Monitor: DONE cycle observed -> check its timing, then HI/LO one cycle later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done === 1'b1) begin
                done_seen++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_done_cycle"}, cyc, e.done_cyc);
                    @(negedge clk);
                    check({e.name, "_hi"}, hi, e.hi);
                    check({e.name, "_lo"}, lo, e.lo);
                    check({e.name, "_done_width"}, done, 0);
                    arch_hi = e.hi;
                    arch_lo = e.lo;
                end
            end
        end
    end

    task automatic push_exp(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b, int acc_cyc, string name);
        exp_t        e;
        logic [2*W-1:0] r;
        r = ref_mdu(op, a, b);
        e.hi = r[2*W-1:W];
        e.lo = r[W-1:0];
        e.done_cyc = acc_cyc + W;
        e.name = name;
        sb.push_back(e);
        issued++;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", {62'd0, busy, done}, 0);
    endtask

    task automatic do_op(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b, string name);
        wait_idle();
        srcA = a;
        srcB = b;
        alu_control = op;
        start = 1'b1;
        @(posedge clk);
        #1;
        push_exp(op, a, b, cyc, name);
        start = 1'b0;
        srcA = $urandom;
        srcB = $urandom;
        alu_control = 4'($urandom_range(0, 15));
        @(negedge clk);
        check({name, "_busy"}, busy, 1);
    endtask

    task automatic comb_check(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b, string name);
        logic [W:0] r;
        @(negedge clk);
        start = 1'b0;
        srcA = a;
        srcB = b;
        alu_control = op;
        #1;
        r = ref_alu(op, a, b, arch_hi, arch_lo);
        check({name, "_result"}, alu_result, r[W-1:0]);
        check({name, "_zero"}, zero, (r[W-1:0] == '0));
        check({name, "_overflow"}, overflow, r[W]);
    endtask

    initial begin
        logic [3:0]   op;
        logic [W-1:0] a, b;
        int           acc_cyc, k;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        @(negedge clk) rst_n = 1'b1;

        comb_check(4'h2, 32'h7FFF_FFFF, 32'h1, "add_ovf");
        comb_check(4'h6, 32'd5, 32'd5, "sub_zero");
        comb_check(4'h7, 32'hFFFF_FFFF, 32'h1, "slt");
        comb_check(4'h5, 32'hFFFF_FFFF, 32'h1, "sltu");
        comb_check(4'h4, 32'h0, 32'h0, "nor");
        comb_check(4'h6, 32'h8000_0000, 32'h1, "sub_ovf");

        do_op(4'b1000, -32'sd3, 32'd5, "mult_neg");
        do_op(4'b1001, 32'hFFFF_FFFF, 32'd2, "multu");
        do_op(4'b1011, 32'd100, 32'd7, "divu");
        do_op(4'b1010, -32'sd7, 32'd2, "div_neg");
        do_op(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF, "div_minneg");
        do_op(4'b1010, 32'd5, 32'd0, "div_zero");
        do_op(4'b1011, 32'hDEAD_BEEF, 32'd0, "divu_zero");
        do_op(4'b1000, 32'h8000_0000, 32'h8000_0000, "mult_minneg");

        for (int i = 0; i < 24; i++) begin
            op = 4'b1000 | 4'($urandom_range(0, 3));
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : 32'($urandom);
            if ($urandom_range(0, 5) == 0) b = -b;
            do_op(op, a, b, "rand_mdu");
        end
        wait_idle();
        wait_idle();

        comb_check(4'hC, $urandom, $urandom, "mfhi");
        comb_check(4'hD, $urandom, $urandom, "mflo");
        for (int i = 0; i < 40; i++)
            comb_check(4'($urandom_range(0, 15)), $urandom, $urandom, "rand_comb");

        // Start held high across the whole operation with churning operands.
        wait_idle();
        srcA = 32'h1234_5678;
        srcB = 32'h0000_9ABC;
        alu_control = 4'b1001;
        start = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        push_exp(4'b1001, 32'h1234_5678, 32'h0000_9ABC, acc_cyc, "hold_multu");
        k = 0;
        while (k < 60) begin
            @(negedge clk);
            if (done) break;
            srcA = $urandom;
            srcB = $urandom;
            alu_control = (k == 5) ? 4'hD : 4'b1010;
            #1;
            if (k == 5) check("mflo_during_busy", alu_result, arch_lo);
            k++;
        end
        check("hold_done_seen", done, 1);
        @(negedge clk);
        srcA = 32'd1000;
        srcB = 32'd3;
        alu_control = 4'b1011;
        @(posedge clk);
        #1;
        check("back_to_back_accept", cyc - acc_cyc, W + 2);
        push_exp(4'b1011, 32'd1000, 32'd3, cyc, "b2b_divu");
        start = 1'b0;
        wait_idle();
        wait_idle();

        // Reset in the middle of a multiply.
        srcA = 32'd7;
        srcB = 32'd9;
        alu_control = 4'b1000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midop_reset_busy", busy, 0);
        check("midop_reset_done", done, 0);
        check("midop_reset_hi", hi, 0);
        check("midop_reset_lo", lo, 0);
        arch_hi = '0;
        arch_lo = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (45) @(negedge clk);
        check("post_reset_idle", busy, 0);

        check("scoreboard_empty", sb.size(), 0);
        check("done_count", done_seen, issued);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0d required<%0d", cyc, 200000);
        $fatal(1, "timeout");
    end

endmodule
